// File: rtl/cmsdk_ahb_sram_ws.sv
// cmsdk_ahb_sram_ws: AHB-Lite SRAM slave with per-type wait states, optional BE8 lane mapping,
// a one-entry write buffer with read forwarding and a two-cycle ERROR response.
module cmsdk_ahb_sram_ws #(
  parameter int AW   = 14,
  parameter int WS_N = 0,
  parameter int WS_S = 0,
  parameter int BE   = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP
);
  localparam int         DEPTH  = 1 << (AW - 2);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;
  localparam logic [1:0] WSN    = 2'(WS_N);
  localparam logic [1:0] WSS    = 2'(WS_S);
  localparam logic [1:0] LANE_X = (BE != 0) ? 2'b11 : 2'b00;

  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << (a ^ LANE_X);
      3'd1:    s = (a[1] ^ LANE_X[1]) ? 4'b1100 : 4'b0011;
      3'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (base & ~mask) | (data & mask);
  endfunction

  logic [1:0]    state_q, state_d, cnt_q, cnt_d;
  logic          hready_q, hready_d, hresp_q, hresp_d;
  logic          dp_act_q, dp_act_d, dp_wr_q, dp_wr_d;
  logic [AW-3:0] dp_addr_q, dp_addr_d;
  logic [3:0]    dp_strb_q, dp_strb_d;
  logic          buf_vld_q, buf_vld_d;
  logic [AW-3:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_strb_q, buf_strb_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];

  logic          accept_s, legal_s, wr_done_s, commit_s, rd_load_s;
  logic [1:0]    ws_s;
  logic [AW-3:0] rd_addr_s;
  logic [31:0]   rd_mem_s, rd_buf_s, rd_word_s;

  // Address-phase decode and data-phase completion strobes.
  always_comb begin
    accept_s = HSEL & HREADY & HTRANS[1] & (state_q != S_ERR1);
    ws_s     = (HTRANS == 2'b11) ? WSS : WSN;
    case (HSIZE)
      3'd0:    legal_s = 1'b1;
      3'd1:    legal_s = ~HADDR[0];
      3'd2:    legal_s = (HADDR[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
    wr_done_s = dp_act_q & dp_wr_q & hready_q;
    commit_s  = wr_done_s & buf_vld_q;
  end

  // Response FSM; a new accept reloads the wait counter even in the final data-phase cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      if (!legal_s) begin
        state_d = S_ERR1;
        cnt_d   = 2'd0;
      end else if (ws_s != 2'd0) begin
        state_d = S_WAIT;
        cnt_d   = ws_s;
      end else begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q <= 2'd1) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        S_ERR1:  state_d = S_ERR2;
        S_ERR2:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    hready_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  // Data-phase record of the accepted transfer, plus the write buffer.
  always_comb begin
    dp_act_d   = dp_act_q;
    dp_wr_d    = dp_wr_q;
    dp_addr_d  = dp_addr_q;
    dp_strb_d  = dp_strb_q;
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_strb_d = buf_strb_q;
    buf_data_d = buf_data_q;
    if (accept_s) begin
      dp_act_d  = legal_s;
      dp_wr_d   = HWRITE;
      dp_addr_d = HADDR[AW-1:2];
      dp_strb_d = lane_strb(HSIZE, HADDR[1:0]);
    end else if (hready_q) begin
      dp_act_d = 1'b0;
    end else begin
      dp_act_d = dp_act_q;
    end
    if (wr_done_s) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = dp_addr_q;
      buf_strb_d = dp_strb_q;
      buf_data_d = HWDATA;
    end else begin
      buf_vld_d = buf_vld_q;
    end
  end

  // Read data: array word, then buffered bytes, then a write completing this very cycle.
  always_comb begin
    rd_load_s = (accept_s & legal_s & ~HWRITE & (ws_s == 2'd0)) |
                ((state_q == S_WAIT) & (cnt_q == 2'd1) & dp_act_q & ~dp_wr_q);
    rd_addr_s = accept_s ? HADDR[AW-1:2] : dp_addr_q;
    rd_mem_s  = mem[rd_addr_s];
    if (buf_vld_q && (buf_addr_q == rd_addr_s)) begin
      rd_buf_s = merge(rd_mem_s, buf_data_q, buf_strb_q);
    end else begin
      rd_buf_s = rd_mem_s;
    end
    if (wr_done_s && (dp_addr_q == rd_addr_s)) begin
      rd_word_s = merge(rd_buf_s, HWDATA, dp_strb_q);
    end else begin
      rd_word_s = rd_buf_s;
    end
    rdata_d = rd_load_s ? rd_word_s : rdata_q;
  end

  // Control, buffer and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      dp_act_q   <= 1'b0;
      dp_wr_q    <= 1'b0;
      dp_addr_q  <= '0;
      dp_strb_q  <= 4'd0;
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_strb_q <= 4'd0;
      buf_data_q <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      dp_act_q   <= dp_act_d;
      dp_wr_q    <= dp_wr_d;
      dp_addr_q  <= dp_addr_d;
      dp_strb_q  <= dp_strb_d;
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_strb_q <= buf_strb_d;
      buf_data_q <= buf_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is not reset; the previous buffer entry drains when a new write is captured.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      mem[buf_addr_q] <= merge(mem[buf_addr_q], buf_data_q, buf_strb_q);
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;
endmodule
